// File: rtl/pc_fetch_sequencer_pkg.sv
// rtl/pc_fetch_sequencer_pkg.sv - shared types, default vectors and target helpers for the fetch sequencer
package pc_fetch_sequencer_pkg;

   // Sequencer states; S_HALT is only left through reset.
   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Which source produced the next PC.
   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } sel_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
   localparam logic [7:0]  DEF_ACK_TIMEOUT  = 8'd255;

   // Branch offset is a word offset; the shift drops the top two bits, giving a plain 32-bit wrap.
   function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [31:0] offset);
      return pc4 + {offset[29:0], 2'b00};
   endfunction

   // J/JAL keep the 256 MB region of the delay-slot address (PC+4), not of the jump itself.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] index);
      return {pc4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - instruction-memory fetch handshake between sequencer and imem
interface pc_fetch_sequencer_if;

   logic        fetch_req;
   logic        fetch_ack;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   modport master (
      output fetch_req,
      output pc_out,
      output pc_plus4,
      input  fetch_ack
   );

   modport slave (
      input  fetch_req,
      input  pc_out,
      input  pc_plus4,
      output fetch_ack
   );

endinterface

// File: rtl/pc_fetch_sequencer_next_sel.sv
// rtl/pc_fetch_sequencer_next_sel.sv - combinational next-PC selection with jr > jump > branch > sequential priority
module pc_fetch_sequencer_next_sel
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic [31:0] pc_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_offset_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   output logic [31:0] next_pc_o,
   output sel_t        sel_o,
   output logic        misalign_o
);

   logic [31:0] pc4;

   assign pc4 = pc_i + 32'd4;

   // Priority redirect mux; a misaligned JR target diverts to the exception vector.
   always_comb begin
      next_pc_o  = pc4;
      sel_o      = SEL_SEQ;
      misalign_o = 1'b0;
      if (jr_i) begin
         sel_o = SEL_JR;
         if (jr_target_i[1:0] == 2'b00) begin
            next_pc_o = jr_target_i;
         end else begin
            next_pc_o  = EXC_VECTOR;
            misalign_o = 1'b1;
         end
      end else if (jump_i) begin
         sel_o     = SEL_J;
         next_pc_o = jump_target(pc4, jump_index_i);
      end else if (branch_taken_i) begin
         sel_o     = SEL_BR;
         next_pc_o = branch_target(pc4, branch_offset_i);
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner and fetch/execute sequencing FSM
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
   parameter logic [7:0]  ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pc_fetch_sequencer_if.master     imem,
   output logic                     instr_valid_o,
   input  logic                     stall_i,
   input  logic                     branch_taken_i,
   input  logic [31:0]              branch_offset_i,
   input  logic                     jump_i,
   input  logic [25:0]              jump_index_i,
   input  logic                     jr_i,
   input  logic [31:0]              jr_target_i,
   output logic                     addr_err_o,
   output logic                     fetch_err_o
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        fetch_err_q, fetch_err_d;
   logic        addr_err_q, addr_err_d;

   logic [31:0] next_pc;
   sel_t        next_sel;
   logic        next_misalign;

   pc_fetch_sequencer_next_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_sel (
      .pc_i            (pc_q),
      .branch_taken_i  (branch_taken_i),
      .branch_offset_i (branch_offset_i),
      .jump_i          (jump_i),
      .jump_index_i    (jump_index_i),
      .jr_i            (jr_i),
      .jr_target_i     (jr_target_i),
      .next_pc_o       (next_pc),
      .sel_o           (next_sel),
      .misalign_o      (next_misalign)
   );

   // State, PC, timeout counter and error flags; reset forces everything back to boot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_VECTOR;
         cnt_q       <= 8'd0;
         fetch_err_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         fetch_err_q <= fetch_err_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Next-state logic; the PC only moves when leaving S_EXEC unstalled, and ack beats the timeout.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      fetch_err_d = fetch_err_q;
      addr_err_d  = 1'b0;
      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
         end
         S_FETCH: begin
            if (imem.fetch_ack) begin
               state_d = S_EXEC;
            end else if (cnt_q == (ACK_TIMEOUT - 8'd1)) begin
               state_d     = S_HALT;
               fetch_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_EXEC: begin
            if (!stall_i) begin
               state_d    = S_FETCH;
               pc_d       = next_pc;
               cnt_d      = 8'd0;
               addr_err_d = (next_sel == SEL_JR) && next_misalign;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   assign imem.fetch_req = (state_q == S_FETCH);
   assign imem.pc_out    = pc_q;
   assign imem.pc_plus4  = pc_q + 32'd4;
   assign instr_valid_o  = (state_q == S_EXEC);
   assign addr_err_o     = addr_err_q;
   assign fetch_err_o    = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed table-driven bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_target;
   logic        addr_err;
   logic        fetch_err;

   int total = 0;
   int bad   = 0;

   pc_fetch_sequencer_if imem ();

   pc_fetch_sequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem            (imem),
      .instr_valid_o   (instr_valid),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_offset_i (branch_offset),
      .jump_i          (jump),
      .jump_index_i    (jump_index),
      .jr_i            (jr),
      .jr_target_i     (jr_target),
      .addr_err_o      (addr_err),
      .fetch_err_o     (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] start_pc;
      logic        br;
      logic [31:0] off;
      logic        j;
      logic [25:0] idx;
      logic        jr;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic        exp_ae;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for a request, acknowledge it, land in S_EXEC.
   task automatic do_fetch(input string nm);
      int n;
      n = 0;
      while (imem.fetch_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      if (imem.fetch_req !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL %s_req_wait: got %b expected 1", nm, imem.fetch_req);
      end
      imem.fetch_ack = 1'b1;
      tick();
      imem.fetch_ack = 1'b0;
      check({nm, "_exec"}, {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic clear_redirects();
      branch_taken  = 1'b0;
      branch_offset = 32'd0;
      jump          = 1'b0;
      jump_index    = 26'd0;
      jr            = 1'b0;
      jr_target     = 32'd0;
   endtask

   initial begin
      int n;
      rst_n          = 1'b0;
      stall          = 1'b0;
      imem.fetch_ack = 1'b0;
      clear_redirects();

      vecs[0] = '{32'h0FFF_FFFC, 1'b0, 32'h0,         1'b1, 26'h000_0010, 1'b0, 32'h0,      32'h1000_0040, 1'b0};
      vecs[1] = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,        1'b0, 32'h0,      32'h0000_00FC, 1'b0};
      vecs[2] = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h000_0040, 1'b0, 32'h0,      32'h0000_0100, 1'b0};
      vecs[3] = '{32'h0000_0200, 1'b0, 32'h0,         1'b0, 26'h0,        1'b1, 32'h2002,   32'h0000_0080, 1'b1};
      vecs[4] = '{32'h0000_0200, 1'b0, 32'h0,         1'b0, 26'h0,        1'b1, 32'h2000,   32'h0000_2000, 1'b0};
      vecs[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,      32'h0000_0000, 1'b0};
      vecs[6] = '{32'h0000_1000, 1'b1, 32'h10,        1'b1, 26'h3FF_FFFF, 1'b1, 32'h3000,   32'h0000_3000, 1'b0};
      vecs[7] = '{32'h7FFF_FFF0, 1'b1, 32'h1000_0000, 1'b0, 26'h0,        1'b0, 32'h0,      32'hBFFF_FFF4, 1'b0};
      vecs[8] = '{32'h0000_0040, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,      32'h0000_0044, 1'b0};
      vecs[9] = '{32'hFFFF_FFF8, 1'b1, 32'h1,         1'b0, 26'h0,        1'b0, 32'h0,      32'h0000_0000, 1'b0};

      // Reset state
      tick();
      tick();
      check("rst_pc", imem.pc_out, 32'h0);
      check("rst_req", {31'd0, imem.fetch_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_addr_err", {31'd0, addr_err}, 32'd0);
      check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

      // Sequential fetch, ack right after each request
      rst_n = 1'b1;
      check("boot_no_req", {31'd0, imem.fetch_req}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq%0d_req", i), {31'd0, imem.fetch_req}, 32'd1);
         check($sformatf("seq%0d_pc", i), imem.pc_out, 32'(i * 4));
         check($sformatf("seq%0d_pc4", i), imem.pc_plus4, 32'(i * 4 + 4));
         imem.fetch_ack = 1'b1;
         tick();
         imem.fetch_ack = 1'b0;
         check($sformatf("seq%0d_valid", i), {31'd0, instr_valid}, 32'd1);
         check($sformatf("seq%0d_exec_pc", i), imem.pc_out, 32'(i * 4));
         tick();
      end

      // Next-PC vectors: load start PC through an aligned JR, then apply the redirect
      for (int v = 0; v < 10; v++) begin
         do_fetch($sformatf("v%0d_a", v));
         jr        = 1'b1;
         jr_target = vecs[v].start_pc;
         tick();
         clear_redirects();
         check($sformatf("v%0d_load", v), imem.pc_out, vecs[v].start_pc);
         do_fetch($sformatf("v%0d_b", v));
         branch_taken  = vecs[v].br;
         branch_offset = vecs[v].off;
         jump          = vecs[v].j;
         jump_index    = vecs[v].idx;
         jr            = vecs[v].jr;
         jr_target     = vecs[v].tgt;
         tick();
         clear_redirects();
         check($sformatf("v%0d_pc", v), imem.pc_out, vecs[v].exp_pc);
         check($sformatf("v%0d_addr_err", v), {31'd0, addr_err}, {31'd0, vecs[v].exp_ae});
         check($sformatf("v%0d_req", v), {31'd0, imem.fetch_req}, 32'd1);
         tick();
         check($sformatf("v%0d_addr_err_drop", v), {31'd0, addr_err}, 32'd0);
      end

      // Redirects ignored in S_FETCH, then stall holds S_EXEC
      do_fetch("st_a");
      jr        = 1'b1;
      jr_target = 32'h500;
      tick();
      clear_redirects();
      jump       = 1'b1;
      jump_index = 26'h3FF_FFFF;
      tick();
      clear_redirects();
      check("fetch_ignores_jump", imem.pc_out, 32'h500);
      check("fetch_still_req", {31'd0, imem.fetch_req}, 32'd1);
      do_fetch("st_b");
      stall          = 1'b1;
      branch_taken   = 1'b1;
      branch_offset  = 32'd4;
      imem.fetch_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall%0d_pc", k), imem.pc_out, 32'h500);
         check($sformatf("stall%0d_valid", k), {31'd0, instr_valid}, 32'd1);
         check($sformatf("stall%0d_req", k), {31'd0, imem.fetch_req}, 32'd0);
      end
      imem.fetch_ack = 1'b0;
      stall          = 1'b0;
      tick();
      clear_redirects();
      check("unstall_branch_pc", imem.pc_out, 32'h514);
      check("unstall_req", {31'd0, imem.fetch_req}, 32'd1);

      // Ack timeout
      n = 0;
      while (fetch_err !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd255);
      check("timeout_err", {31'd0, fetch_err}, 32'd1);
      check("halt_no_req", {31'd0, imem.fetch_req}, 32'd0);
      imem.fetch_ack = 1'b1;
      tick();
      tick();
      imem.fetch_ack = 1'b0;
      check("halt_pc_frozen", imem.pc_out, 32'h514);
      check("halt_no_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_err_sticky", {31'd0, fetch_err}, 32'd1);
      check("halt_req_held", {31'd0, imem.fetch_req}, 32'd0);

      // Reset from halt clears everything
      rst_n = 1'b0;
      #2;
      check("rst2_err", {31'd0, fetch_err}, 32'd0);
      check("rst2_pc", imem.pc_out, 32'h0);
      check("rst2_req", {31'd0, imem.fetch_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Ack on the cycle the timeout would fire wins
      for (int k = 0; k < 254; k++) tick();
      check("edge_no_err", {31'd0, fetch_err}, 32'd0);
      check("edge_req", {31'd0, imem.fetch_req}, 32'd1);
      imem.fetch_ack = 1'b1;
      tick();
      imem.fetch_ack = 1'b0;
      check("edge_ack_valid", {31'd0, instr_valid}, 32'd1);
      check("edge_ack_no_err", {31'd0, fetch_err}, 32'd0);
      tick();
      check("edge_next_pc", imem.pc_out, 32'h4);

      // Asynchronous reset in the middle of a fetch
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("async_req_drop", {31'd0, imem.fetch_req}, 32'd0);
      check("async_pc", imem.pc_out, 32'h0);
      check("async_valid", {31'd0, instr_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
